// File: rtl/wb2stream_host.sv
// Purpose: Wishbone slave that tunnels register accesses as 5-byte command frames over a byte link and runs SYNC bring-up.
// Latency: posted write acks 1 cycle after the 10th tx byte; reads ack 1 cycle after the 4th rx byte, or after TIMEOUT rx cycles.
// Backpressure: tx bytes held stable until tx_ready; rx is never stalled (rx_ready=1); wb_cyc is held until wb_ack.
module wb2stream_host #(
    parameter int unsigned TIMEOUT = 1023,
    parameter bit          WR_SYNC = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] wb_addr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        sync_req,
    output logic        link_ok,
    output logic        err,
    input  logic        err_clr
);

    typedef enum logic [2:0] {
        IDLE, TX_DSET, TX_REG, TX_DGET, TX_SYNC, RX_RESP, ACK
    } state_t;

    localparam logic [15:0] TMO       = 16'(TIMEOUT);
    localparam logic [31:0] SYNC_WORD = 32'hCAFEBABE;

    state_t      state_q, state_d;
    logic [2:0]  txcnt_q, txcnt_d;
    logic [1:0]  rxcnt_q, rxcnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] rdata_q, rdata_d;
    logic        link_ok_q, link_ok_d;
    logic        err_q, err_d;
    logic        pend_q, pend_d;
    logic        we_q, we_d;
    logic        sync_op_q, sync_op_d;
    logic [19:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        tx_hs, last_byte, err_set;
    logic [3:0]  code;
    logic [31:0] payload;

    assign tx_valid = (state_q == TX_DSET) || (state_q == TX_REG) ||
                      (state_q == TX_DGET) || (state_q == TX_SYNC);
    assign tx_hs     = tx_valid && tx_ready;
    assign last_byte = tx_hs && (txcnt_q == 3'd4);
    assign wb_ack    = (state_q == ACK);
    assign wb_rdata  = rdata_q;
    assign link_ok   = link_ok_q;
    assign err       = err_q;
    assign rx_ready  = 1'b1;

    // Frame byte mux: header byte first, then payload MSB first; purely a function of registered state.
    always_comb begin
        code    = 4'h0;
        payload = 32'h0;
        unique case (state_q)
            TX_DSET: begin code = 4'h2; payload = wdata_q; end
            TX_REG:  begin code = 4'h1; payload = {11'h0, ~we_q, addr_q[19:16], addr_q[15:0]}; end
            TX_DGET: begin code = 4'h3; end
            default: begin code = 4'h0; end
        endcase
        unique case (txcnt_q)
            3'd0:    tx_data = {code, 4'h0};
            3'd1:    tx_data = payload[31:24];
            3'd2:    tx_data = payload[23:16];
            3'd3:    tx_data = payload[15:8];
            default: tx_data = payload[7:0];
        endcase
    end

    // Next-state logic for the access/sync sequencer and its datapath registers.
    always_comb begin
        state_d   = state_q;
        txcnt_d   = txcnt_q;
        rxcnt_d   = rxcnt_q;
        tmo_d     = tmo_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        link_ok_d = link_ok_q;
        pend_d    = pend_q | sync_req;
        we_d      = we_q;
        sync_op_d = sync_op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_set   = 1'b0;

        if (tx_hs) begin
            txcnt_d = last_byte ? 3'd0 : txcnt_q + 3'd1;
        end

        unique case (state_q)
            IDLE: begin
                // A wb access wins a tie with sync_req; the sync stays pending.
                if (wb_cyc) begin
                    we_d      = wb_we;
                    addr_d    = wb_addr;
                    wdata_d   = wb_wdata;
                    sync_op_d = 1'b0;
                    state_d   = wb_we ? TX_DSET : TX_REG;
                end else if (pend_q || sync_req) begin
                    pend_d    = 1'b0;
                    sync_op_d = 1'b1;
                    state_d   = TX_SYNC;
                end
            end
            TX_DSET: if (last_byte) state_d = TX_REG;
            TX_REG: begin
                if (last_byte) state_d = (!we_q || WR_SYNC) ? TX_DGET : ACK;
            end
            TX_DGET, TX_SYNC: begin
                if (last_byte) begin
                    state_d = RX_RESP;
                    tmo_d   = 16'd0;
                    rxcnt_d = 2'd0;
                end
            end
            RX_RESP: begin
                // RX_RESP lasts at most TIMEOUT cycles; a 4th byte in the final cycle still completes normally.
                tmo_d = tmo_q + 16'd1;
                if (rx_valid) begin
                    shift_d = {shift_q[23:0], rx_data};
                    rxcnt_d = rxcnt_q + 2'd1;
                end
                if (rx_valid && rxcnt_q == 2'd3) begin
                    if (sync_op_q) begin
                        link_ok_d = (shift_d == SYNC_WORD);
                        err_set   = (shift_d != SYNC_WORD);
                        state_d   = IDLE;
                    end else begin
                        if (!we_q) rdata_d = shift_d;
                        state_d = ACK;
                    end
                end else if (tmo_d == TMO) begin
                    err_set = 1'b1;
                    if (sync_op_q) begin
                        link_ok_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        rdata_d = 32'hFFFFFFFF;
                        state_d = ACK;
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Clear first so a same-cycle set wins.
        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (err_set) err_d = 1'b1;
    end

    // State and datapath registers; reset mid-frame drops tx_valid at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            txcnt_q   <= 3'd0;
            rxcnt_q   <= 2'd0;
            tmo_q     <= 16'd0;
            shift_q   <= 32'h0;
            rdata_q   <= 32'h0;
            link_ok_q <= 1'b0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            we_q      <= 1'b0;
            sync_op_q <= 1'b0;
            addr_q    <= 20'h0;
            wdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            txcnt_q   <= txcnt_d;
            rxcnt_q   <= rxcnt_d;
            tmo_q     <= tmo_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            link_ok_q <= link_ok_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            we_q      <= we_d;
            sync_op_q <= sync_op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule

// File: tb/tb_wb2stream_host.sv
// Purpose: scoreboard bench for wb2stream_host; expected tx bytes and wb acks queued by stimulus, checked by a monitor.
// Latency: checks posted-write, read and timeout ack timing relative to the last tx/rx byte.
// Backpressure: toggles tx_ready during a write and checks tx_data holds while stalled.
module tb_wb2stream_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic [31:0] wb_rdata;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        sync_req = 1'b0;
    logic        link_ok;
    logic        err;
    logic        err_clr = 1'b0;

    wb2stream_host #(.TIMEOUT(16), .WR_SYNC(1'b0)) dut (
        .clk(clk), .rst(rst),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .sync_req(sync_req), .link_ok(link_ok), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tx_hs_cnt = 0;
    int last_hs_cyc = 0;
    int ack_cnt = 0;
    int ack_cyc = 0;
    int rx_last_cyc = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    bit done = 1'b0;
    logic [31:0] exp_rdata = 32'h0;

    // {any, byte}: any=1 means the payload byte value is don't-care
    logic [8:0]  exp_tx_q[$];
    logic [31:0] exp_ack_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: consumes tx handshakes and wb acks and compares against the queues.
    always @(negedge clk) begin
        logic [8:0]  e;
        logic [31:0] r;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("tx_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, prev_data});
            if (tx_valid && tx_ready) begin
                tx_hs_cnt++;
                last_hs_cyc = cyc;
                if (exp_tx_q.size() == 0) begin
                    fail("tx_unexpected", {24'h0, tx_data}, 32'h0);
                end else begin
                    e = exp_tx_q.pop_front();
                    if (!e[8]) chk("tx_byte", {24'h0, tx_data}, {24'h0, e[7:0]});
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (rx_valid) rx_last_cyc = cyc;
            if (wb_ack) begin
                ack_cnt++;
                ack_cyc = cyc;
                if (exp_ack_q.size() == 0) begin
                    fail("ack_unexpected", wb_rdata, 32'h0);
                end else begin
                    r = exp_ack_q.pop_front();
                    chk("wb_rdata", wb_rdata, r);
                end
            end
        end
    end

    task automatic push_frame(input logic [3:0] code, input logic [31:0] pl, input bit any);
        exp_tx_q.push_back({1'b0, code, 4'h0});
        for (int i = 0; i < 4; i++) exp_tx_q.push_back({any, pl[31-8*i -: 8]});
    endtask

    task automatic wb_access(input logic [19:0] a, input logic we, input logic [31:0] wd, input bit with_sync);
        int start;
        int guard;
        @(posedge clk); #1;
        wb_addr = a; wb_we = we; wb_wdata = wd; wb_cyc = 1'b1; sync_req = with_sync;
        start = ack_cnt;
        @(posedge clk); #1;
        sync_req = 1'b0;
        guard = 0;
        while (ack_cnt == start && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        if (ack_cnt == start) fail("ack_wait", 32'd0, 32'd1);
        #1;
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic respond(input int target, input int delay, input logic [31:0] w);
        int guard;
        guard = 0;
        while (tx_hs_cnt < target && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        if (tx_hs_cnt < target) begin
            fail("rx_wait", tx_hs_cnt, target);
        end else begin
            repeat (delay) @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                rx_data  = w[31-8*i -: 8];
                rx_valid = 1'b1;
                @(posedge clk); #1;
            end
            rx_valid = 1'b0;
        end
    endtask

    task automatic do_sync(input logic [31:0] w);
        int base;
        base = tx_hs_cnt;
        push_frame(4'h0, 32'h0, 1'b1);
        @(posedge clk); #1 sync_req = 1'b1;
        @(posedge clk); #1 sync_req = 1'b0;
        respond(base + 5, 2, w);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    initial begin
        int base;
        int guard;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
        chk("rst_wb_ack",   {31'h0, wb_ack},   32'd0);
        chk("rst_wb_rdata", wb_rdata,          32'h0);
        chk("rst_link_ok",  {31'h0, link_ok},  32'd0);
        chk("rst_err",      {31'h0, err},      32'd0);
        chk("rx_ready",     {31'h0, rx_ready}, 32'd1);
        rst = 1'b0;

        // Posted write: 20 12 34 56 78 10 00 02 00 10, ack 1 cycle after 10th byte
        base = tx_hs_cnt;
        push_frame(4'h2, 32'h12345678, 1'b0);
        push_frame(4'h1, 32'h00020010, 1'b0);
        exp_ack_q.push_back(exp_rdata);
        wb_access(20'h2_0010, 1'b1, 32'h12345678, 1'b0);
        chk("wr_latency", ack_cyc, last_hs_cyc + 1);
        chk("wr_tx_count", tx_hs_cnt - base, 32'd10);

        // Read: 10 00 10 00 04 30 xx xx xx xx, remote answers DEADBEEF 8 cycles later
        base = tx_hs_cnt;
        push_frame(4'h1, 32'h00100004, 1'b0);
        push_frame(4'h3, 32'h0, 1'b1);
        exp_rdata = 32'hDEADBEEF;
        exp_ack_q.push_back(exp_rdata);
        fork
            wb_access(20'h0_0004, 1'b0, 32'h0, 1'b0);
            respond(base + 10, 8, 32'hDEADBEEF);
        join
        chk("rd_latency", ack_cyc, rx_last_cyc + 1);

        // Write with tx_ready toggling; rdata must keep the last read value
        base = tx_hs_cnt;
        push_frame(4'h2, 32'hA5A50F0F, 1'b0);
        push_frame(4'h1, 32'h0001ABCD, 1'b0);
        exp_ack_q.push_back(exp_rdata);
        done = 1'b0;
        fork
            begin
                wb_access(20'h1_ABCD, 1'b1, 32'hA5A50F0F, 1'b0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    tx_ready = ~tx_ready;
                end
                tx_ready = 1'b1;
            end
        join
        chk("stall_tx_count", tx_hs_cnt - base, 32'd10);

        // SYNC good then bad
        do_sync(32'hCAFEBABE);
        chk("sync_ok_link", {31'h0, link_ok}, 32'd1);
        chk("sync_ok_err",  {31'h0, err},     32'd0);
        do_sync(32'hCAFEBABF);
        chk("sync_bad_link", {31'h0, link_ok}, 32'd0);
        chk("sync_bad_err",  {31'h0, err},     32'd1);
        pulse_err_clr();
        chk("err_clr", {31'h0, err}, 32'd0);

        // Read and sync_req in the same cycle: read frame first, then SYNC
        base = tx_hs_cnt;
        push_frame(4'h1, 32'h00130001, 1'b0);
        push_frame(4'h3, 32'h0, 1'b1);
        push_frame(4'h0, 32'h0, 1'b1);
        exp_rdata = 32'h11223344;
        exp_ack_q.push_back(exp_rdata);
        fork
            wb_access(20'h3_0001, 1'b0, 32'h0, 1'b1);
            respond(base + 10, 2, 32'h11223344);
        join
        respond(base + 15, 2, 32'hCAFEBABE);
        repeat (3) @(posedge clk);
        #1;
        chk("tie_sync_link", {31'h0, link_ok}, 32'd1);
        chk("tie_tx_count", tx_hs_cnt - base, 32'd15);

        // Read timeout with TIMEOUT=16: RX_RESP for 16 cycles, then ack with FFFFFFFF
        push_frame(4'h1, 32'h00100008, 1'b0);
        push_frame(4'h3, 32'h0, 1'b1);
        exp_rdata = 32'hFFFFFFFF;
        exp_ack_q.push_back(exp_rdata);
        wb_access(20'h0_0008, 1'b0, 32'h0, 1'b0);
        chk("tmo_latency", ack_cyc, last_hs_cyc + 17);
        chk("tmo_err", {31'h0, err}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            rx_data  = 8'h11 * 8'(i + 1);
            rx_valid = 1'b1;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        pulse_err_clr();
        chk("tmo_err_clr", {31'h0, err}, 32'd0);
        base = tx_hs_cnt;
        push_frame(4'h1, 32'h0010000C, 1'b0);
        push_frame(4'h3, 32'h0, 1'b1);
        exp_rdata = 32'h01020304;
        exp_ack_q.push_back(exp_rdata);
        fork
            wb_access(20'h0_000C, 1'b0, 32'h0, 1'b0);
            respond(base + 10, 3, 32'h01020304);
        join
        chk("post_tmo_err", {31'h0, err}, 32'd0);

        // Reset in TX_REG: tx_valid drops in the same cycle
        base = tx_hs_cnt;
        push_frame(4'h2, 32'h0, 1'b0);
        push_frame(4'h1, 32'h00000044, 1'b0);
        @(posedge clk); #1;
        wb_addr = 20'h0_0044; wb_we = 1'b1; wb_wdata = 32'h0; wb_cyc = 1'b1;
        guard = 0;
        while (tx_hs_cnt < base + 6 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        #1;
        chk("txreg_valid", {31'h0, tx_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid",   {31'h0, tx_valid}, 32'd0);
        chk("rst_mid_rdata",   wb_rdata,          32'h0);
        chk("rst_mid_link_ok", {31'h0, link_ok},  32'd0);
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
        exp_tx_q.delete();
        exp_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_sync(32'hCAFEBABE);
        chk("resync_link", {31'h0, link_ok}, 32'd1);
        base = tx_hs_cnt;
        push_frame(4'h1, 32'h00120020, 1'b0);
        push_frame(4'h3, 32'h0, 1'b1);
        exp_rdata = 32'h0BADF00D;
        exp_ack_q.push_back(exp_rdata);
        fork
            wb_access(20'h2_0020, 1'b0, 32'h0, 1'b0);
            respond(base + 10, 4, 32'h0BADF00D);
        join

        repeat (5) @(posedge clk);
        chk("tx_queue_drained",  exp_tx_q.size(),  32'd0);
        chk("ack_queue_drained", exp_ack_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        fail("watchdog", 32'd0, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
